// File: rtl/tensor_cpu_pkg.sv
// tensor_cpu_pkg: shared opcodes, FSM states, status bit indices and instruction field positions
// Used by tensor_cpu_alu and tensor_cpu_pipe; no ports.
package tensor_cpu_pkg;

    typedef enum logic [7:0] {
        OP_ADD     = 8'h00,
        OP_SUB     = 8'h01,
        OP_MUL     = 8'h02,
        OP_EQL     = 8'h03,
        OP_GRT     = 8'h04,
        OP_TC_OP   = 8'h05,
        OP_TC_LOAD = 8'h06,
        OP_CPU2TC  = 8'h07,
        OP_NOP     = 8'h08,
        OP_ADDI    = 8'h09,
        OP_SUBI    = 8'h0A,
        OP_MOV     = 8'h0B,
        OP_MOVTC   = 8'h0C,
        OP_RESET   = 8'h0D,
        OP_TC2CPU  = 8'h0E,
        OP_RDCPU   = 8'h0F,
        OP_RDTC    = 8'h10
    } opcode_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_TC_WAIT = 1'b1
    } state_e;

    localparam int STAT_SIGN    = 0;
    localparam int STAT_ZERO    = 1;
    localparam int STAT_CARRY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_PARITY  = 4;
    localparam int STAT_TIMEOUT = 5;
    localparam int STAT_W       = 6;

    localparam int F_OP_LSB   = 0;
    localparam int F_SRC2_LSB = 8;
    localparam int F_SRC1_LSB = 16;
    localparam int F_DST_LSB  = 24;
    localparam int F_W        = 8;

    function automatic logic is_alu_op(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_EQL, OP_GRT, OP_ADDI, OP_SUBI, OP_MOV};
    endfunction

    // Instructions that touch the tensor side and must wait for the engine.
    function automatic logic is_tc_op(input opcode_e op);
        return op inside {OP_TC_OP, OP_TC_LOAD, OP_CPU2TC, OP_MOVTC, OP_RESET, OP_TC2CPU, OP_RDTC};
    endfunction

    function automatic logic has_result(input opcode_e op);
        return is_alu_op(op) || op inside {OP_TC2CPU, OP_RDCPU, OP_RDTC};
    endfunction

endpackage

// File: rtl/tensor_cpu_pipe_if.sv
// tensor_cpu_pipe_if: instruction handshake, result/status and tensor engine/register-file bus
// Ports: instruction valid/ready/word, cpu_output(+valid), status_out, tc_start/done,
// tc write strobe/address/data, tc read address/data. slave = CPU side, master = environment.
interface tensor_cpu_pipe_if #(
    parameter int DATA_WIDTH = 8,
    parameter int TC_DIM     = 4
);
    localparam int TC_AW = $clog2(2 * TC_DIM * TC_DIM);

    logic                  instr_valid_in;
    logic [31:0]           instr_in;
    logic                  instr_ready_out;
    logic [DATA_WIDTH-1:0] cpu_output;
    logic                  cpu_output_valid_out;
    logic [5:0]            status_out;
    logic                  tc_start_out;
    logic                  tc_done_in;
    logic                  tc_write_enable_out;
    logic [TC_AW-1:0]      tc_write_address_out;
    logic [DATA_WIDTH-1:0] tc_write_data_out;
    logic [TC_AW-1:0]      tc_read_address_out;
    logic [DATA_WIDTH-1:0] tc_read_data_in;

    modport master (
        output instr_valid_in, instr_in, tc_done_in, tc_read_data_in,
        input  instr_ready_out, cpu_output, cpu_output_valid_out, status_out, tc_start_out,
               tc_write_enable_out, tc_write_address_out, tc_write_data_out, tc_read_address_out
    );

    modport slave (
        input  instr_valid_in, instr_in, tc_done_in, tc_read_data_in,
        output instr_ready_out, cpu_output, cpu_output_valid_out, status_out, tc_start_out,
               tc_write_enable_out, tc_write_address_out, tc_write_data_out, tc_read_address_out
    );

endinterface

// File: rtl/tensor_cpu_alu.sv
// tensor_cpu_alu: combinational ALU (opcode, a, b -> result, flags[4:0] = parity/ovf/carry/zero/sign)
// Ports: op, a, b in; result, flags out. SATURATING_ALU_EN clamps ADD/SUB/ADDI/SUBI/MUL on overflow.
import tensor_cpu_pkg::*;

module tensor_cpu_alu #(
    parameter int DATA_WIDTH = 8
) (
    input  opcode_e                      op,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0]        result,
    output logic [STAT_TIMEOUT-1:0]      flags
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
`ifdef SATURATING_ALU_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic [W:0]            sum_u;
    logic [W:0]            dif_u;
    logic signed [2*W-1:0] prod;
    logic [W-1:0]          raw;
    logic                  ov;
    logic                  cy;
    logic                  neg;

    always_comb begin
        sum_u = {1'b0, a} + {1'b0, b};
        dif_u = {1'b0, a} - {1'b0, b};
        prod  = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        raw   = '0;
        ov    = 1'b0;
        cy    = 1'b0;
        // direction of clamp: sign of the true (unwrapped) result
        neg   = (op == OP_MUL) ? prod[2*W-1] : a[W-1];
        case (op)
            OP_ADD, OP_ADDI: begin
                raw = sum_u[W-1:0];
                cy  = sum_u[W];
                ov  = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
            end
            OP_SUB, OP_SUBI: begin
                raw = dif_u[W-1:0];
                cy  = dif_u[W];
                ov  = (a[W-1] != b[W-1]) && (raw[W-1] != a[W-1]);
            end
            OP_MUL: begin
                raw = prod[W-1:0];
                cy  = |prod[2*W-1:W];
                // fits in W bits only when the top W+1 bits are all equal
                ov  = |prod[2*W-1:W-1] && !(&prod[2*W-1:W-1]);
            end
            OP_EQL:  raw = {{(W-1){1'b0}}, a == b};
            OP_GRT:  raw = {{(W-1){1'b0}}, a > b};
            OP_MOV:  raw = a;
            default: raw = '0;
        endcase
        result              = (SAT && ov) ? (neg ? SMIN : SMAX) : raw;
        flags               = '0;
        flags[STAT_SIGN]    = result[W-1];
        flags[STAT_ZERO]    = result == '0;
        flags[STAT_CARRY]   = cy;
        flags[STAT_OVF]     = ov;
        flags[STAT_PARITY]  = ^result;
    end

endmodule

// File: rtl/tensor_cpu_pipe.sv
// tensor_cpu_pipe: scalar/tensor CPU with valid/ready issue, registered result and tensor scoreboard
// Ports: clock_in, reset_n_in (async active-low), bus (tensor_cpu_pipe_if.slave).
// Optional macro SATURATING_ALU_EN (inside tensor_cpu_alu) selects clamping arithmetic.
import tensor_cpu_pkg::*;

module tensor_cpu_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int TC_DIM     = 4,
    parameter int TC_TIMEOUT = 64
) (
    input  logic           clock_in,
    input  logic           reset_n_in,
    tensor_cpu_pipe_if.slave bus
);
    localparam int AW  = $clog2(NUM_REGS);
    localparam int TAW = $clog2(2 * TC_DIM * TC_DIM);
    localparam int CW  = $clog2(TC_TIMEOUT + 1);

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t             regs_q [NUM_REGS];
    word_t             regs_d [NUM_REGS];
    logic [STAT_W-1:0] status_q, status_d;
    word_t             out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              start_q, start_d;
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    opcode_e                  op;
    logic [AW-1:0]            dst, src1, src2;
    word_t                    ra, rb, imm, alu_b, alu_res;
    logic [STAT_TIMEOUT-1:0]  alu_flags;
    logic                     accept;
    logic                     unused_instr;

    assign op           = opcode_e'(bus.instr_in[F_OP_LSB +: F_W]);
    assign dst          = bus.instr_in[F_DST_LSB +: AW];
    assign src1         = bus.instr_in[F_SRC1_LSB +: AW];
    assign src2         = bus.instr_in[F_SRC2_LSB +: AW];
    assign imm          = bus.instr_in[F_SRC2_LSB +: DATA_WIDTH];
    assign ra           = regs_q[src1];
    assign rb           = regs_q[src2];
    assign alu_b        = (op == OP_ADDI || op == OP_SUBI) ? imm : rb;
    assign unused_instr = ^bus.instr_in;

    // Ready depends only on registered state, so a done pulse frees stalled ops one cycle later.
    assign bus.instr_ready_out      = reset_n_in && (state_q == ST_IDLE || !is_tc_op(op));
    assign accept                   = bus.instr_valid_in && bus.instr_ready_out;
    assign bus.tc_read_address_out  = bus.instr_in[F_SRC1_LSB +: TAW];
    assign bus.tc_write_enable_out  = accept && op inside {OP_TC_LOAD, OP_CPU2TC, OP_MOVTC};
    assign bus.tc_write_address_out = bus.instr_in[F_DST_LSB +: TAW];
    assign bus.tc_write_data_out    = (op == OP_TC_LOAD) ? imm : (op == OP_CPU2TC) ? ra : bus.tc_read_data_in;
    assign bus.cpu_output           = out_q;
    assign bus.cpu_output_valid_out = out_valid_q;
    assign bus.status_out           = status_q;
    assign bus.tc_start_out         = start_q;

    tensor_cpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op     (op),
        .a      (ra),
        .b      (alu_b),
        .result (alu_res),
        .flags  (alu_flags)
    );

    always_comb begin
        regs_d      = regs_q;
        status_d    = status_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (accept) begin
            if (is_alu_op(op)) begin
                regs_d[dst]                = alu_res;
                status_d[STAT_TIMEOUT-1:0] = alu_flags;
            end
            if (op == OP_TC2CPU)
                regs_d[dst] = bus.tc_read_data_in;
            if (op == OP_RESET) begin
                regs_d   = '{default: '0};
                status_d = '0;
            end
            if (has_result(op)) begin
                out_valid_d = 1'b1;
                out_d       = (op == OP_TC2CPU || op == OP_RDTC) ? bus.tc_read_data_in :
                              (op == OP_RDCPU) ? ra : alu_res;
            end
        end
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (accept && op == OP_TC_OP) begin
                start_d = 1'b1;
                state_d = ST_TC_WAIT;
                cnt_d   = '0;
            end
        end else if (bus.tc_done_in) begin
            state_d = ST_IDLE;
        end else if (cnt_q == CW'(TC_TIMEOUT - 1)) begin
            state_d                = ST_IDLE;
            status_d[STAT_TIMEOUT] = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            status_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            start_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
        end else begin
            regs_q      <= regs_d;
            status_q    <= status_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            start_q     <= start_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tensor_cpu_pipe.sv
// tb_tensor_cpu_pipe: directed and randomized checks of tensor_cpu_pipe against a behavioural model
module tb_tensor_cpu_pipe;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    tensor_cpu_pipe_if #(.DATA_WIDTH(8), .TC_DIM(4)) bus ();

    tensor_cpu_pipe #(.DATA_WIDTH(8), .NUM_REGS(4), .TC_DIM(4), .TC_TIMEOUT(64)) dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (bus.slave)
    );

    logic [7:0] tmem [32];
    assign bus.tc_read_data_in = tmem[bus.tc_read_address_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       mregs [4];
    bit [5:0] mstat;
    bit       busy;
    int       start_edge;
    int       edge_n;
    logic       s_rdy;
    logic       s_we;
    logic [4:0] s_wa;
    logic [7:0] s_wd;

    function automatic logic [31:0] mk(input int d, input int a, input int b, input int op);
        return {8'(d), 8'(a), 8'(b), 8'(op)};
    endfunction

    function automatic int sx(input int v);
        return v >= 128 ? v - 256 : v;
    endfunction

    function automatic void alu_model(input int op, input int a, input int b, output int r, output bit [4:0] f);
        int s;
        bit cy, ov;
        int ua, ub;
        ua = a & 255;
        ub = b & 255;
        cy = 1'b0;
        case (op)
            0, 9:    begin s = a + b; cy = (ua + ub) > 255; end
            1, 10:   begin s = a - b; cy = ua < ub; end
            2:       begin s = a * b; cy = ((s & 'hFFFF) >> 8) != 0; end
            3:       s = (a == b) ? 1 : 0;
            4:       s = (a > b) ? 1 : 0;
            default: s = a;
        endcase
        ov = s > 127 || s < -128;
        r  = ((s & 255) ^ 128) - 128;
`ifdef SATURATING_ALU_EN
        if (ov) r = s > 127 ? 127 : -128;
`endif
        f = {^8'(r), ov, cy, r == 0, r < 0};
    endfunction

    task automatic model_reset();
        foreach (mregs[i]) mregs[i] = 0;
        mstat = '0;
        busy  = 1'b0;
    endtask

    // One clock cycle: present inputs, check handshake/write side, cross the edge, check registered side.
    task automatic step(input bit v, input logic [31:0] ins, input bit done);
        int op, d, s1, s2, a, b, r, eout, ewa, ewd;
        bit tcc, rdy, acc, ewe, ev, es;
        bit [4:0] f;
        bus.instr_valid_in = v;
        bus.instr_in       = ins;
        bus.tc_done_in     = done;
        #1;
        op   = int'(ins[7:0]);
        d    = int'(ins[25:24]);
        s1   = int'(ins[17:16]);
        s2   = int'(ins[9:8]);
        tcc  = op inside {5, 6, 7, 12, 13, 14, 16};
        rdy  = !busy || !tcc;
        acc  = v && rdy;
        ewe  = acc && (op inside {6, 7, 12});
        ewa  = int'(ins[28:24]);
        ewd  = op == 6 ? int'(ins[15:8]) : op == 7 ? mregs[s1] : int'(tmem[ins[20:16]]);
        s_rdy = bus.instr_ready_out;
        s_we  = bus.tc_write_enable_out;
        s_wa  = bus.tc_write_address_out;
        s_wd  = bus.tc_write_data_out;
        checks++;
        if (s_rdy !== rdy) begin
            failures++;
            $display("FAIL ready op=%02h got=%b exp=%b", op, s_rdy, rdy);
        end
        checks++;
        if (s_we !== ewe || (ewe && (s_wa !== 5'(ewa) || s_wd !== 8'(ewd)))) begin
            failures++;
            $display("FAIL tc_write op=%02h got we=%b a=%0d d=%02h exp we=%b a=%0d d=%02h", op, s_we, s_wa, s_wd, ewe, ewa, ewd);
        end
        checks++;
        if (bus.tc_read_address_out !== ins[20:16]) begin
            failures++;
            $display("FAIL tc_read_addr got=%0d exp=%0d", bus.tc_read_address_out, ins[20:16]);
        end
        ev   = 1'b0;
        es   = 1'b0;
        eout = 0;
        if (acc) begin
            if (op inside {0, 1, 2, 3, 4, 9, 10, 11}) begin
                a = sx(mregs[s1]);
                b = (op inside {9, 10}) ? sx(int'(ins[15:8])) : sx(mregs[s2]);
                alu_model(op, a, b, r, f);
                eout        = r & 255;
                mregs[d]    = eout;
                mstat[4:0]  = f;
                ev          = 1'b1;
            end else if (op == 14) begin
                eout     = int'(tmem[ins[20:16]]);
                mregs[d] = eout;
                ev       = 1'b1;
            end else if (op == 15) begin
                eout = mregs[s1];
                ev   = 1'b1;
            end else if (op == 16) begin
                eout = int'(tmem[ins[20:16]]);
                ev   = 1'b1;
            end else if (op == 13) begin
                foreach (mregs[i]) mregs[i] = 0;
                mstat = '0;
            end
        end
        if (!busy) begin
            if (acc && op == 5) begin
                busy       = 1'b1;
                start_edge = edge_n;
                es         = 1'b1;
            end
        end else if (done) begin
            busy = 1'b0;
        end else if (edge_n - start_edge == 64) begin
            busy     = 1'b0;
            mstat[5] = 1'b1;
        end
        @(posedge clk);
        edge_n++;
        #1;
        checks++;
        if (bus.cpu_output_valid_out !== ev || (ev && bus.cpu_output !== 8'(eout))) begin
            failures++;
            $display("FAIL result op=%02h got v=%b d=%02h exp v=%b d=%02h", op, bus.cpu_output_valid_out, bus.cpu_output, ev, eout);
        end
        checks++;
        if (bus.status_out !== mstat) begin
            failures++;
            $display("FAIL status op=%02h got=%06b exp=%06b", op, bus.status_out, mstat);
        end
        checks++;
        if (bus.tc_start_out !== es) begin
            failures++;
            $display("FAIL tc_start got=%b exp=%b", bus.tc_start_out, es);
        end
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        bus.instr_valid_in = 1'b0;
        bus.instr_in       = '0;
        bus.tc_done_in     = 1'b0;
        foreach (tmem[i]) tmem[i] = 8'($urandom);
        model_reset();
        edge_n = 0;
        #2;
        checks++;
        if ({bus.cpu_output, bus.cpu_output_valid_out, bus.status_out, bus.tc_start_out, bus.tc_write_enable_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got out=%02h v=%b st=%06b start=%b we=%b exp all 0", bus.cpu_output,
                     bus.cpu_output_valid_out, bus.status_out, bus.tc_start_out, bus.tc_write_enable_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        edge_n++;
        #1;
        checks++;
        if (bus.instr_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", bus.instr_ready_out);
        end
    endtask

    task automatic test_alu_basic();
        step(1, mk(1, 0, 5, 8'h09), 0);
        checks++;
        if (bus.cpu_output !== 8'd5) begin
            failures++;
            $display("FAIL addi_result got=%0d exp=5", bus.cpu_output);
        end
        step(1, mk(2, 1, 1, 8'h00), 0);
        checks++;
        if (bus.cpu_output !== 8'd10 || bus.status_out[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL add_result got=%0d zs=%02b exp=10 zs=00", bus.cpu_output, bus.status_out[1:0]);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_v;
`ifdef SATURATING_ALU_EN
        exp_v = 8'd127;
`else
        exp_v = 8'hC8;
`endif
        step(1, mk(1, 0, 100, 8'h09), 0);
        step(1, mk(2, 1, 1, 8'h00), 0);
        checks++;
        if (bus.cpu_output !== exp_v || bus.status_out[3] !== 1'b1) begin
            failures++;
            $display("FAIL add_overflow got=%02h ovf=%b exp=%02h ovf=1", bus.cpu_output, bus.status_out[3], exp_v);
        end
    endtask

    task automatic test_tc_scoreboard();
        int n;
        step(1, mk(0, 0, 0, 8'h05), 0);
        step(1, mk(3, 1, 1, 8'h00), 0);
        checks++;
        if (s_rdy !== 1'b1 || bus.cpu_output_valid_out !== 1'b1 || bus.tc_start_out !== 1'b0) begin
            failures++;
            $display("FAIL scalar_during_wait got rdy=%b v=%b start=%b exp 1 1 0", s_rdy, bus.cpu_output_valid_out, bus.tc_start_out);
        end
        for (int i = 0; i < 3; i++) step(1, mk(7, 0, 8'h5A, 8'h06), 0);
        step(1, mk(7, 0, 8'h5A, 8'h06), 1);
        checks++;
        if (s_rdy !== 1'b0) begin
            failures++;
            $display("FAIL stall_on_done got rdy=%b exp=0", s_rdy);
        end
        n = 0;
        do begin
            step(1, mk(7, 0, 8'h5A, 8'h06), 0);
            n++;
        end while (!s_rdy && n < 4);
        checks++;
        if (n !== 1 || s_we !== 1'b1 || s_wa !== 5'd7 || s_wd !== 8'h5A) begin
            failures++;
            $display("FAIL tc_load_release got cycles=%0d we=%b a=%0d d=%02h exp cycles=1 we=1 a=7 d=5a", n, s_we, s_wa, s_wd);
        end
    endtask

    task automatic test_timeout();
        step(1, mk(0, 0, 0, 8'h05), 0);
        for (int i = 0; i < 64; i++) step(1, mk(0, 0, 0, 8'h08), 0);
        checks++;
        if (bus.status_out[5] !== 1'b1) begin
            failures++;
            $display("FAIL timeout_flag got=%b exp=1", bus.status_out[5]);
        end
        step(1, mk(0, 0, 0, 8'h0D), 0);
        checks++;
        if (s_rdy !== 1'b1 || bus.status_out !== 6'd0) begin
            failures++;
            $display("FAIL reset_op got rdy=%b st=%06b exp rdy=1 st=0", s_rdy, bus.status_out);
        end
    endtask

    task automatic test_alias_tc2cpu();
        step(1, mk(8'h05, 0, 8'h21, 8'h09), 0);
        step(1, mk(0, 1, 0, 8'h0F), 0);
        checks++;
        if (bus.cpu_output !== 8'h21) begin
            failures++;
            $display("FAIL alias_r1 got=%02h exp=21", bus.cpu_output);
        end
        step(1, mk(8'h06, 3, 0, 8'h0E), 0);
        step(1, mk(0, 2, 0, 8'h0F), 0);
        checks++;
        if (bus.cpu_output !== tmem[3]) begin
            failures++;
            $display("FAIL tc2cpu got=%02h exp=%02h", bus.cpu_output, tmem[3]);
        end
    endtask

    task automatic test_async_reset();
        step(1, mk(0, 0, 0, 8'h05), 0);
        step(1, mk(1, 1, 1, 8'h00), 0);
        bus.instr_valid_in = 1'b1;
        bus.instr_in       = mk(2, 0, 3, 8'h06);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.cpu_output, bus.cpu_output_valid_out, bus.status_out, bus.tc_start_out, bus.tc_write_enable_out, bus.instr_ready_out} !== '0) begin
            failures++;
            $display("FAIL async_reset got out=%02h v=%b st=%06b start=%b we=%b rdy=%b exp all 0", bus.cpu_output,
                     bus.cpu_output_valid_out, bus.status_out, bus.tc_start_out, bus.tc_write_enable_out, bus.instr_ready_out);
        end
        bus.instr_valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        edge_n++;
        #1;
        step(1, mk(0, 0, 0, 8'h08), 1);
        step(1, mk(2, 0, 3, 8'h06), 0);
        checks++;
        if (s_rdy !== 1'b1 || s_we !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_ready got rdy=%b we=%b exp 1 1", s_rdy, s_we);
        end
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 18));
            step($urandom_range(0, 9) < 8, {8'($urandom), 8'($urandom), 8'($urandom), 8'(op)}, $urandom_range(0, 19) == 0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_alu_basic();
        test_overflow();
        test_tc_scoreboard();
        test_timeout();
        test_alias_tc2cpu();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
